dmem_initiator: RTL and testbench

- Processor-side initiator for data memory. It is the requester end of the 1 MiB byte-addressed data memory used by the SEQ memory stage.
- Takes one memory-stage request (icode, valA, valB, valE, valP) and performs it as eight sequential byte transactions over a req/ack byte bus.
- For reads, reassembles the 64-bit valM. Flags dmem_error for out-of-range addresses or a responder timeout.
- Byte order is big-endian: bits 63:56 go to the lowest address.

---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_op_decode.sv | 19 +
 rtl/dmem_initiator.sv | 126 ++++++++++++
 tb/tb_dmem_initiator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared icode constants, sequencer states and memory size for the data-memory initiator
package dmem_pkg;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET = 4'h9;
  localparam logic [3:0] IPUSHQ = 4'hA;
  localparam logic [3:0] IPOPQ = 4'hB;
  localparam int MEM_BYTES_DEF = 1048576;
  typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;
endpackage

// File: rtl/dmem_op_decode.sv
// dmem_op_decode: maps a memory-stage icode to direction, address source and write-data source
module dmem_op_decode
  import dmem_pkg::*;
(
  input  logic [3:0]  icode_i,
  input  logic [63:0] val_a_i,
  input  logic [63:0] val_b_i,
  input  logic [63:0] val_e_i,
  input  logic [63:0] val_p_i,
  output logic        is_read_o,
  output logic        is_write_o,
  output logic [63:0] addr_o,
  output logic [63:0] wdata_o
);
  assign is_write_o = icode_i == IRMMOVQ || icode_i == IPUSHQ || icode_i == ICALL;
  assign is_read_o = icode_i == IMRMOVQ || icode_i == IPOPQ || icode_i == IRET;
  assign addr_o = (icode_i == IPOPQ || icode_i == IRET) ? val_b_i : val_e_i;
  assign wdata_o = icode_i == ICALL ? val_p_i : val_a_i;
endmodule

// File: rtl/dmem_initiator.sv
// dmem_initiator: runs one memory-stage access as eight big-endian byte transactions on a req/ack bus
module dmem_initiator
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic [63:0]       valA,
  input  logic [63:0]       valB,
  input  logic [63:0]       valE,
  input  logic [63:0]       valP,
  output logic              busy,
  output logic              done,
  output logic [63:0]       valM,
  output logic              dmem_error,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic              bus_ack,
  input  logic [7:0]        bus_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic rd_q, rd_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [63:0] wdata_q, wdata_d, valm_q, valm_d;
  logic [55:0] shadow_q, shadow_d;
  logic [2:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dec_rd, dec_wr, oob;
  logic [63:0] dec_addr, dec_wdata;
  logic [64:0] last_addr;
  dmem_op_decode u_dec (
    .icode_i(icode),
    .val_a_i(valA),
    .val_b_i(valB),
    .val_e_i(valE),
    .val_p_i(valP),
    .is_read_o(dec_rd),
    .is_write_o(dec_wr),
    .addr_o(dec_addr),
    .wdata_o(dec_wdata)
  );
  // 65-bit sum so an address near 2^64 cannot wrap into range
  assign last_addr = {1'b0, dec_addr} + 65'd7;
  assign oob = last_addr > 65'(MEM_BYTES - 1);
  always_comb begin
    state_d = state_q;
    rd_d = rd_q;
    we_d = we_q;
    err_d = err_q;
    base_d = base_q;
    wdata_d = wdata_q;
    valm_d = valm_q;
    shadow_d = shadow_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: if (start) begin
        rd_d = dec_rd;
        we_d = dec_wr;
        base_d = dec_addr[ADDR_W-1:0];
        wdata_d = dec_wdata;
        idx_d = '0;
        cnt_d = '0;
        err_d = (dec_rd || dec_wr) && oob;
        state_d = (dec_rd || dec_wr) && !oob ? XFER : FIN;
      end
      XFER: if (bus_ack) begin
        cnt_d = '0;
        shadow_d = {shadow_q[47:0], bus_rdata};
        idx_d = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? FIN : XFER;
        valm_d = idx_q == 3'd7 && rd_q ? {shadow_q, bus_rdata} : valm_q;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        cnt_d = '0;
        err_d = 1'b1;
        state_d = FIN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      base_q <= '0;
      wdata_q <= '0;
      valm_q <= '0;
      shadow_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      we_q <= we_d;
      err_q <= err_d;
      base_q <= base_d;
      wdata_q <= wdata_d;
      valm_q <= valm_d;
      shadow_q <= shadow_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign valM = valm_q;
  assign dmem_error = err_q;
  assign bus_req = state_q == XFER;
  assign bus_we = bus_req && we_q;
  assign bus_addr = bus_req ? base_q + ADDR_W'(idx_q) : '0;
  // ~idx selects byte 7-idx, so idx 0 drives bits 63:56
  assign bus_wdata = bus_req ? wdata_q[{~idx_q, 3'b000} +: 8] : '0;
endmodule

// File: tb/tb_dmem_initiator.sv
// tb_dmem_initiator: directed checks of the data-memory initiator against a byte-memory responder
module tb_dmem_initiator;
  logic clk = 0, reset = 1, start = 0;
  logic [3:0] icode = 0;
  logic [63:0] valA = 0, valB = 0, valE = 0, valP = 0;
  logic busy, done, dmem_error, bus_req, bus_we;
  logic [63:0] valM;
  logic [19:0] bus_addr;
  logic [7:0] bus_wdata;
  logic bus_ack = 0;
  logic [7:0] bus_rdata = 0;
  int vectors = 0, miscompares = 0;
  int wait_n = 0, wcnt = 0;
  bit ack_off = 0;
  logic [7:0] mem [int];
  logic [19:0] log_a[$];
  logic [7:0] log_d[$];
  bit log_w[$];
  int req_cycles = 0, stab_err = 0;
  bit pend = 0;
  logic [19:0] pa;
  logic [7:0] pd;
  logic pw;

  always #5 clk = ~clk;

  dmem_initiator #(.ADDR_W(20), .MEM_BYTES(1048576), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode),
    .valA(valA), .valB(valB), .valE(valE), .valP(valP),
    .busy(busy), .done(done), .valM(valM), .dmem_error(dmem_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // responder: acks after wait_n idle cycles per byte
  always @(negedge clk) begin
    if (bus_req === 1'b1 && !ack_off) begin
      if (wcnt == wait_n) begin
        bus_ack = 1;
        bus_rdata = mem.exists(int'(bus_addr)) ? mem[int'(bus_addr)] : 8'h00;
        wcnt = 0;
      end else begin
        bus_ack = 0;
        wcnt++;
      end
    end else begin
      bus_ack = 0;
      wcnt = 0;
    end
  end

  always @(posedge clk) begin
    if (bus_req === 1'b1) begin
      req_cycles++;
      if (pend && (bus_addr !== pa || bus_wdata !== pd || bus_we !== pw)) stab_err++;
      if (bus_ack) begin
        log_a.push_back(bus_addr);
        log_d.push_back(bus_wdata);
        log_w.push_back(bus_we);
        if (bus_we) mem[int'(bus_addr)] = bus_wdata;
      end
    end
    pend = bus_req === 1'b1 && !bus_ack;
    pa = bus_addr;
    pd = bus_wdata;
    pw = bus_we;
  end

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
    log_w.delete();
  endtask

  task automatic do_op(input logic [3:0] ic, input logic [63:0] a, b, e, p, input int pulse_at, output int lat);
    @(negedge clk);
    icode = ic; valA = a; valB = b; valE = e; valP = p; start = 1;
    @(posedge clk);
    #1 start = 0;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = (k == pulse_at);
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 0;
    if (lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL op_done_wait got no done want done within 300 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (valM !== 0) begin miscompares++; $display("FAIL reset_valM got %h want 0", valM); end
    vectors++; if (dmem_error !== 0) begin miscompares++; $display("FAIL reset_err got %b want 0", dmem_error); end
    vectors++; if (bus_req !== 0) begin miscompares++; $display("FAIL reset_req got %b want 0", bus_req); end
    vectors++; if (bus_we !== 0) begin miscompares++; $display("FAIL reset_we got %b want 0", bus_we); end
    vectors++; if (bus_addr !== 0) begin miscompares++; $display("FAIL reset_addr got %h want 0", bus_addr); end
    vectors++; if (bus_wdata !== 0) begin miscompares++; $display("FAIL reset_wdata got %h want 0", bus_wdata); end
    reset = 0;
  endtask

  task automatic test_rmmovq();
    int lat;
    logic [63:0] d = 64'h0123456789ABCDEF;
    clear_log();
    do_op(4'h4, d, 64'h0, 64'h100, 64'h0, 0, lat);
    vectors++; if (busy !== 1) begin miscompares++; $display("FAIL rmmovq_busy_at_done got %b want 1", busy); end
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL rmmovq_latency got %0d want 9", lat); end
    vectors++; if (log_a.size() !== 8) begin miscompares++; $display("FAIL rmmovq_bytes got %0d want 8", log_a.size()); end
    for (int i = 0; i < log_a.size() && i < 8; i++) begin
      vectors++;
      if (log_a[i] !== 20'(32'h100 + i) || log_w[i] !== 1 || log_d[i] !== d[63-8*i -: 8]) begin
        miscompares++;
        $display("FAIL rmmovq_byte%0d got a=%h w=%b d=%h want a=%h w=1 d=%h", i, log_a[i], log_w[i], log_d[i], 32'h100 + i, d[63-8*i -: 8]);
      end
    end
    vectors++; if (dmem_error !== 0) begin miscompares++; $display("FAIL rmmovq_err got %b want 0", dmem_error); end
    vectors++; if (valM !== 64'h0) begin miscompares++; $display("FAIL rmmovq_valM got %h want 0", valM); end
  endtask

  task automatic test_mrmovq();
    int lat;
    for (int i = 0; i < 8; i++) mem[32'h200 + i] = 8'(8'h11 * (i + 1));
    clear_log();
    do_op(4'h5, 64'h0, 64'h0, 64'h200, 64'h0, 0, lat);
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL mrmovq_latency got %0d want 9", lat); end
    vectors++; if (valM !== 64'h1122334455667788) begin miscompares++; $display("FAIL mrmovq_valM got %h want 1122334455667788", valM); end
    vectors++; if (log_a.size() !== 8) begin miscompares++; $display("FAIL mrmovq_bytes got %0d want 8", log_a.size()); end
    for (int i = 0; i < log_a.size() && i < 8; i++) begin
      vectors++;
      if (log_a[i] !== 20'(32'h200 + i) || log_w[i] !== 0) begin
        miscompares++;
        $display("FAIL mrmovq_byte%0d got a=%h w=%b want a=%h w=0", i, log_a[i], log_w[i], 32'h200 + i);
      end
    end
  endtask

  task automatic test_popq_call();
    int lat;
    for (int i = 0; i < 8; i++) mem[32'h300 + i] = 8'(8'hA0 + i);
    clear_log();
    do_op(4'hB, 64'h0, 64'h300, 64'h308, 64'h0, 0, lat);
    vectors++; if (valM !== 64'hA0A1A2A3A4A5A6A7) begin miscompares++; $display("FAIL popq_valM got %h want a0a1a2a3a4a5a6a7", valM); end
    vectors++; if (log_a.size() !== 8) begin miscompares++; $display("FAIL popq_bytes got %0d want 8", log_a.size()); end
    for (int i = 0; i < log_a.size() && i < 8; i++) begin
      vectors++;
      if (log_a[i] !== 20'(32'h300 + i)) begin miscompares++; $display("FAIL popq_addr%0d got %h want %h", i, log_a[i], 32'h300 + i); end
    end
    clear_log();
    do_op(4'h8, 64'hDEAD, 64'h0, 64'h3F8, 64'h2A, 0, lat);
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL call_latency got %0d want 9", lat); end
    vectors++; if (log_a.size() !== 8) begin miscompares++; $display("FAIL call_bytes got %0d want 8", log_a.size()); end
    for (int i = 0; i < log_a.size() && i < 8; i++) begin
      vectors++;
      if (log_a[i] !== 20'(32'h3F8 + i) || log_w[i] !== 1 || log_d[i] !== (i == 7 ? 8'h2A : 8'h00)) begin
        miscompares++;
        $display("FAIL call_byte%0d got a=%h w=%b d=%h want a=%h w=1 d=%h", i, log_a[i], log_w[i], log_d[i], 32'h3F8 + i, i == 7 ? 8'h2A : 8'h00);
      end
    end
    vectors++; if (valM !== 64'hA0A1A2A3A4A5A6A7) begin miscompares++; $display("FAIL call_valM_hold got %h want a0a1a2a3a4a5a6a7", valM); end
  endtask

  task automatic test_bounds();
    int lat, rc;
    rc = req_cycles;
    do_op(4'h4, 64'h1, 64'h0, 64'hFFFF9, 64'h0, 0, lat);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL oob1_latency got %0d want 1", lat); end
    vectors++; if (dmem_error !== 1) begin miscompares++; $display("FAIL oob1_err got %b want 1", dmem_error); end
    do_op(4'h4, 64'h1, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 0, lat);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL oob2_latency got %0d want 1", lat); end
    vectors++; if (dmem_error !== 1) begin miscompares++; $display("FAIL oob2_err got %b want 1", dmem_error); end
    vectors++; if (req_cycles !== rc) begin miscompares++; $display("FAIL oob_req_cycles got %0d want %0d", req_cycles, rc); end
    do_op(4'h0, 64'h1, 64'h0, 64'h100, 64'h0, 0, lat);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL noacc_latency got %0d want 1", lat); end
    vectors++; if (dmem_error !== 0) begin miscompares++; $display("FAIL noacc_err got %b want 0", dmem_error); end
    vectors++; if (req_cycles !== rc) begin miscompares++; $display("FAIL noacc_req_cycles got %0d want %0d", req_cycles, rc); end
    clear_log();
    do_op(4'h4, 64'h8877665544332211, 64'h0, 64'hFFFF8, 64'h0, 0, lat);
    vectors++; if (lat !== 9 || dmem_error !== 0) begin miscompares++; $display("FAIL edge_legal got lat=%0d err=%b want lat=9 err=0", lat, dmem_error); end
    vectors++; if (log_a.size() !== 8) begin miscompares++; $display("FAIL edge_bytes got %0d want 8", log_a.size()); end
    else begin
      vectors++; if (log_a[7] !== 20'hFFFFF || log_d[7] !== 8'h11) begin miscompares++; $display("FAIL edge_last got a=%h d=%h want a=fffff d=11", log_a[7], log_d[7]); end
    end
  endtask

  task automatic test_wait_states();
    int lat;
    logic [63:0] d = 64'hCAFEF00D12345678;
    wait_n = 3;
    stab_err = 0;
    clear_log();
    do_op(4'h4, d, 64'h0, 64'h400, 64'h0, 5, lat);
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL wait_latency got %0d want 33", lat); end
    vectors++; if (stab_err !== 0) begin miscompares++; $display("FAIL wait_stability got %0d changes want 0", stab_err); end
    vectors++; if (log_a.size() !== 8) begin miscompares++; $display("FAIL wait_bytes got %0d want 8", log_a.size()); end
    for (int i = 0; i < log_a.size() && i < 8; i++) begin
      vectors++;
      if (log_a[i] !== 20'(32'h400 + i) || log_d[i] !== d[63-8*i -: 8]) begin
        miscompares++;
        $display("FAIL wait_byte%0d got a=%h d=%h want a=%h d=%h", i, log_a[i], log_d[i], 32'h400 + i, d[63-8*i -: 8]);
      end
    end
    repeat (5) @(negedge clk);
    vectors++; if (busy !== 0 || log_a.size() !== 8) begin miscompares++; $display("FAIL wait_ignored_start got busy=%b bytes=%0d want busy=0 bytes=8", busy, log_a.size()); end
    wait_n = 0;
  endtask

  task automatic test_timeout();
    int lat, rc;
    ack_off = 1;
    rc = req_cycles;
    do_op(4'h5, 64'h0, 64'h0, 64'h500, 64'h0, 0, lat);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL timeout_latency got %0d want 5", lat); end
    vectors++; if (req_cycles - rc !== 4) begin miscompares++; $display("FAIL timeout_req_cycles got %0d want 4", req_cycles - rc); end
    vectors++; if (dmem_error !== 1) begin miscompares++; $display("FAIL timeout_err got %b want 1", dmem_error); end
    vectors++; if (valM !== 64'hA0A1A2A3A4A5A6A7) begin miscompares++; $display("FAIL timeout_valM_hold got %h want a0a1a2a3a4a5a6a7", valM); end
    ack_off = 0;
  endtask

  task automatic test_mid_reset();
    bit got_done = 0;
    @(negedge clk);
    icode = 4'h4; valA = 64'h1111; valE = 64'h600; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(negedge clk);
    vectors++; if (bus_req !== 1) begin miscompares++; $display("FAIL midrst_req_T4 got %b want 1", bus_req); end
    reset = 1;
    @(negedge clk);
    vectors++; if (bus_req !== 0 || busy !== 0) begin miscompares++; $display("FAIL midrst_T5 got req=%b busy=%b want 0 0", bus_req, busy); end
    vectors++; if (valM !== 0) begin miscompares++; $display("FAIL midrst_valM got %h want 0", valM); end
    reset = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) got_done = 1;
    end
    vectors++; if (got_done !== 0) begin miscompares++; $display("FAIL midrst_done got %b want 0", got_done); end
  endtask

  initial begin
    test_reset();
    test_rmmovq();
    test_mrmovq();
    test_popq_call();
    test_bounds();
    test_wait_states();
    test_timeout();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
